// File: rtl/l2_fence_ctrl_if.sv
// Decoder-side handshake bundle for the L2 fence sequencer.
interface l2_fence_ctrl_if #(
  parameter int SETS   = 256,
  parameter int WAYS   = 8,
  parameter int N_MSHR = 8
);
  localparam int SW = $clog2(SETS);
  localparam int WW = $clog2(WAYS);
  localparam int MW = $clog2(N_MSHR + 1);

  logic          do_fence;
  logic          fence_flush;
  logic          do_ongoing_fence;
  logic          line_needs_wb;
  logic [MW-1:0] mshr_cnt;
  logic          wb_req_ready;

  logic          ongoing_fence;
  logic          drain_in_progress;
  logic [SW-1:0] flush_set;
  logic [WW-1:0] flush_way;
  logic          wb_req_valid;
  logic          fence_done;
  logic          fence_err;
  logic          fence_timeout;

  modport master (
    output do_fence, fence_flush, do_ongoing_fence, line_needs_wb, mshr_cnt, wb_req_ready,
    input  ongoing_fence, drain_in_progress, flush_set, flush_way, wb_req_valid,
    input  fence_done, fence_err, fence_timeout
  );

  modport slave (
    input  do_fence, fence_flush, do_ongoing_fence, line_needs_wb, mshr_cnt, wb_req_ready,
    output ongoing_fence, drain_in_progress, flush_set, flush_way, wb_req_valid,
    output fence_done, fence_err, fence_timeout
  );
endinterface

// File: rtl/l2_fence_ctrl.sv
// L2 fence sequencer: walks every (set, way) issuing writebacks, then waits for MSHRs to retire.
// Optional drain watchdog enabled by macro L2_FENCE_TIMEOUT_EN.
module l2_fence_ctrl #(
  parameter int SETS           = 256,
  parameter int WAYS           = 8,
  parameter int N_MSHR         = 8,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input logic            clk,
  input logic            rst,
  l2_fence_ctrl_if.slave bus
);
  localparam int SW = $clog2(SETS);
  localparam int WW = $clog2(WAYS);
  localparam int MW = $clog2(N_MSHR + 1);

  localparam logic [SW-1:0] SET_LAST = SW'(SETS - 1);
  localparam logic [WW-1:0] WAY_LAST = WW'(WAYS - 1);
  localparam logic [MW-1:0] MSHR_ALL = MW'(N_MSHR);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WALK  = 3'd1,
    S_WB    = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  state_t        w_adv_state;
  logic [SW-1:0] r_set;
  logic [SW-1:0] w_set_nxt;
  logic [SW-1:0] w_adv_set;
  logic [WW-1:0] r_way;
  logic [WW-1:0] w_way_nxt;
  logic [WW-1:0] w_adv_way;
  logic          r_ongoing;
  logic          r_drain;
  logic          r_wb_valid;
  logic          r_done;
  logic          r_err;
  logic          w_err_nxt;
  logic          w_tmo;

  // Position after one walk step; the final line hands over to DRAIN with counters cleared.
  always_comb begin
    w_adv_state = S_WALK;
    w_adv_set   = r_set;
    w_adv_way   = r_way + WW'(1'b1);
    if (r_way == WAY_LAST) begin
      w_adv_way = {WW{1'b0}};
      if (r_set == SET_LAST) begin
        w_adv_set   = {SW{1'b0}};
        w_adv_state = S_DRAIN;
      end else begin
        w_adv_set = r_set + SW'(1'b1);
      end
    end else begin
      w_adv_set = r_set;
    end
  end

  // Next-state and counter update.
  always_comb begin
    w_state_nxt = r_state;
    w_set_nxt   = r_set;
    w_way_nxt   = r_way;
    case (r_state)
      S_IDLE: begin
        if (bus.do_fence) begin
          w_state_nxt = bus.fence_flush ? S_WALK : S_DRAIN;
          w_set_nxt   = {SW{1'b0}};
          w_way_nxt   = {WW{1'b0}};
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_WALK: begin
        if (bus.do_ongoing_fence && bus.line_needs_wb) begin
          w_state_nxt = S_WB;
        end else if (bus.do_ongoing_fence) begin
          w_state_nxt = w_adv_state;
          w_set_nxt   = w_adv_set;
          w_way_nxt   = w_adv_way;
        end else begin
          w_state_nxt = S_WALK;
        end
      end
      S_WB: begin
        if (bus.wb_req_ready) begin
          w_state_nxt = w_adv_state;
          w_set_nxt   = w_adv_set;
          w_way_nxt   = w_adv_way;
        end else begin
          w_state_nxt = S_WB;
        end
      end
      S_DRAIN: begin
        if (bus.mshr_cnt == MSHR_ALL) begin
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_DRAIN;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: begin
        w_state_nxt = S_IDLE;
        w_set_nxt   = {SW{1'b0}};
        w_way_nxt   = {WW{1'b0}};
      end
    endcase
  end

  assign w_err_nxt = r_err | (bus.do_fence && (r_state != S_IDLE));

  // State, counters and outputs registered from the next state so they change together.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_set      <= {SW{1'b0}};
      r_way      <= {WW{1'b0}};
      r_ongoing  <= 1'b0;
      r_drain    <= 1'b0;
      r_wb_valid <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_set      <= w_set_nxt;
      r_way      <= w_way_nxt;
      r_ongoing  <= (w_state_nxt == S_WALK) || (w_state_nxt == S_WB) || (w_state_nxt == S_DRAIN);
      r_drain    <= (w_state_nxt == S_WB) || (w_state_nxt == S_DRAIN);
      r_wb_valid <= (w_state_nxt == S_WB);
      r_done     <= (w_state_nxt == S_DONE);
      r_err      <= w_err_nxt;
    end
  end

`ifdef L2_FENCE_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYCLES);

  logic [TW-1:0] r_tmo_cnt;
  logic          r_tmo;
  logic          w_enter_drain;

  assign w_enter_drain = (w_state_nxt == S_DRAIN) && (r_state != S_DRAIN);

  // Drain-cycle counter saturates at the limit; the flag is sticky until the next accepted fence.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tmo_cnt <= {TW{1'b0}};
      r_tmo     <= 1'b0;
    end else begin
      if (w_enter_drain) begin
        r_tmo_cnt <= {TW{1'b0}};
      end else if ((r_state == S_DRAIN) && (r_tmo_cnt != TMO_MAX)) begin
        r_tmo_cnt <= r_tmo_cnt + TW'(1'b1);
      end else begin
        r_tmo_cnt <= r_tmo_cnt;
      end
      if ((r_state == S_IDLE) && bus.do_fence) begin
        r_tmo <= 1'b0;
      end else if ((r_state == S_DRAIN) && (r_tmo_cnt == TMO_MAX - TW'(1'b1))) begin
        r_tmo <= 1'b1;
      end else begin
        r_tmo <= r_tmo;
      end
    end
  end

  assign w_tmo = r_tmo;
`else
  assign w_tmo = 1'b0;
`endif

  assign bus.ongoing_fence     = r_ongoing;
  assign bus.drain_in_progress = r_drain;
  assign bus.flush_set         = r_set;
  assign bus.flush_way         = r_way;
  assign bus.wb_req_valid      = r_wb_valid;
  assign bus.fence_done        = r_done;
  assign bus.fence_err         = r_err;
  assign bus.fence_timeout     = w_tmo;
endmodule

// File: tb/tb_l2_fence_ctrl.sv
// Self-checking bench for l2_fence_ctrl: directed scenarios plus randomized run against a line-index model.
module tb_l2_fence_ctrl;
  localparam int SETS   = 2;
  localparam int WAYS   = 2;
  localparam int N_MSHR = 8;
  localparam int TMO    = 16;
  localparam int LINES  = SETS * WAYS;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  l2_fence_ctrl_if #(.SETS(SETS), .WAYS(WAYS), .N_MSHR(N_MSHR)) bus_if ();

  l2_fence_ctrl #(.SETS(SETS), .WAYS(WAYS), .N_MSHR(N_MSHR), .TIMEOUT_CYCLES(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // {ongoing, drain, wb_valid, done}
  function automatic logic [3:0] flags();
    return {bus_if.ongoing_fence, bus_if.drain_in_progress, bus_if.wb_req_valid, bus_if.fence_done};
  endfunction

  function automatic logic [1:0] idx();
    return {bus_if.flush_set, bus_if.flush_way};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    bus_if.do_fence         = 1'b0;
    bus_if.fence_flush      = 1'b0;
    bus_if.do_ongoing_fence = 1'b0;
    bus_if.line_needs_wb    = 1'b0;
    bus_if.mshr_cnt         = 4'(N_MSHR);
    bus_if.wb_req_ready     = 1'b0;
  endtask

  task automatic start_fence(input logic flush);
    bus_if.do_fence    = 1'b1;
    bus_if.fence_flush = flush;
    step();
    bus_if.do_fence    = 1'b0;
    bus_if.fence_flush = 1'b0;
  endtask

  task automatic test_reset();
    quiet();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    n_chk++;
    if (flags() !== 4'b0000) begin n_fail++; $display("FAIL reset_flags got=%b exp=0000", flags()); end
    n_chk++;
    if (idx() !== 2'b00) begin n_fail++; $display("FAIL reset_idx got=%b exp=00", idx()); end
    n_chk++;
    if ({bus_if.fence_err, bus_if.fence_timeout} !== 2'b00) begin
      n_fail++; $display("FAIL reset_sticky got=%b exp=00", {bus_if.fence_err, bus_if.fence_timeout});
    end
  endtask

  task automatic test_drain_only();
    start_fence(1'b0);
    n_chk++;
    if (flags() !== 4'b1100) begin n_fail++; $display("FAIL drain_only_c1 got=%b exp=1100", flags()); end
    step();
    n_chk++;
    if (flags() !== 4'b0001) begin n_fail++; $display("FAIL drain_only_c2 got=%b exp=0001", flags()); end
    step();
    n_chk++;
    if (flags() !== 4'b0000) begin n_fail++; $display("FAIL drain_only_c3 got=%b exp=0000", flags()); end
  endtask

  task automatic test_clean_walk();
    start_fence(1'b1);
    bus_if.do_ongoing_fence = 1'b1;
    for (int i = 0; i < LINES; i++) begin
      n_chk++;
      if (flags() !== 4'b1000 || idx() !== 2'(i)) begin
        n_fail++; $display("FAIL clean_walk_%0d flags=%b idx=%b exp flags=1000 idx=%b", i, flags(), idx(), 2'(i));
      end
      step();
    end
    bus_if.do_ongoing_fence = 1'b0;
    n_chk++;
    if (flags() !== 4'b1100 || idx() !== 2'b00) begin
      n_fail++; $display("FAIL clean_walk_drain flags=%b idx=%b exp flags=1100 idx=00", flags(), idx());
    end
    step();
    n_chk++;
    if (flags() !== 4'b0001) begin n_fail++; $display("FAIL clean_walk_done got=%b exp=0001", flags()); end
    step();
  endtask

  task automatic test_wb_stall();
    start_fence(1'b1);
    bus_if.do_ongoing_fence = 1'b1;
    step();
    step();
    n_chk++;
    if (flags() !== 4'b1000 || idx() !== 2'b10) begin
      n_fail++; $display("FAIL wb_pre flags=%b idx=%b exp flags=1000 idx=10", flags(), idx());
    end
    bus_if.line_needs_wb = 1'b1;
    step();
    bus_if.do_ongoing_fence = 1'b0;
    bus_if.line_needs_wb    = 1'b0;
    for (int k = 0; k < 4; k++) begin
      bus_if.wb_req_ready = (k == 3);
      n_chk++;
      if (flags() !== 4'b1110 || idx() !== 2'b10) begin
        n_fail++; $display("FAIL wb_hold_%0d flags=%b idx=%b exp flags=1110 idx=10", k, flags(), idx());
      end
      step();
    end
    bus_if.wb_req_ready = 1'b0;
    n_chk++;
    if (flags() !== 4'b1000 || idx() !== 2'b11) begin
      n_fail++; $display("FAIL wb_resume flags=%b idx=%b exp flags=1000 idx=11", flags(), idx());
    end
    bus_if.do_ongoing_fence = 1'b1;
    step();
    bus_if.do_ongoing_fence = 1'b0;
    n_chk++;
    if (flags() !== 4'b1100) begin n_fail++; $display("FAIL wb_drain got=%b exp=1100", flags()); end
    step();
    step();
  endtask

  task automatic test_mshr_drain();
    bus_if.mshr_cnt = 4'd6;
    start_fence(1'b0);
    for (int k = 0; k < 5; k++) begin
      bus_if.do_ongoing_fence = k[0];
      n_chk++;
      if (flags() !== 4'b1100 || idx() !== 2'b00) begin
        n_fail++; $display("FAIL mshr_wait_%0d flags=%b idx=%b exp flags=1100 idx=00", k, flags(), idx());
      end
      step();
    end
    bus_if.mshr_cnt         = 4'(N_MSHR);
    bus_if.do_ongoing_fence = 1'b1;
    n_chk++;
    if (flags() !== 4'b1100) begin n_fail++; $display("FAIL mshr_full_cycle got=%b exp=1100", flags()); end
    step();
    bus_if.do_ongoing_fence = 1'b0;
    n_chk++;
    if (flags() !== 4'b0001 || idx() !== 2'b00) begin
      n_fail++; $display("FAIL mshr_done flags=%b idx=%b exp flags=0001 idx=00", flags(), idx());
    end
    step();
    n_chk++;
    if (flags() !== 4'b0000) begin n_fail++; $display("FAIL mshr_idle got=%b exp=0000", flags()); end
  endtask

  task automatic test_reset_err();
    start_fence(1'b1);
    bus_if.do_ongoing_fence = 1'b1;
    step();
    step();
    bus_if.do_ongoing_fence = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_chk++;
    if (flags() !== 4'b0000 || idx() !== 2'b00 || bus_if.fence_err !== 1'b0) begin
      n_fail++; $display("FAIL rst_midwalk flags=%b idx=%b err=%b exp 0000/00/0", flags(), idx(), bus_if.fence_err);
    end
    start_fence(1'b1);
    bus_if.do_fence         = 1'b1;
    bus_if.do_ongoing_fence = 1'b1;
    step();
    bus_if.do_fence = 1'b0;
    n_chk++;
    if (bus_if.fence_err !== 1'b1 || flags() !== 4'b1000 || idx() !== 2'b01) begin
      n_fail++; $display("FAIL err_walk err=%b flags=%b idx=%b exp 1/1000/01", bus_if.fence_err, flags(), idx());
    end
    step();
    step();
    step();
    bus_if.do_ongoing_fence = 1'b0;
    n_chk++;
    if (flags() !== 4'b1100) begin n_fail++; $display("FAIL err_walk_drain got=%b exp=1100", flags()); end
    step();
    step();
    n_chk++;
    if (bus_if.fence_err !== 1'b1 || flags() !== 4'b0000) begin
      n_fail++; $display("FAIL err_sticky err=%b flags=%b exp 1/0000", bus_if.fence_err, flags());
    end
  endtask

`ifdef L2_FENCE_TIMEOUT_EN
  task automatic test_timeout();
    bus_if.mshr_cnt = 4'd7;
    start_fence(1'b0);
    for (int k = 0; k < 20; k++) begin
      n_chk++;
      if (bus_if.fence_timeout !== (k >= TMO) || flags() !== 4'b1100) begin
        n_fail++; $display("FAIL timeout_c%0d tmo=%b flags=%b exp tmo=%b flags=1100", k, bus_if.fence_timeout, flags(), (k >= TMO));
      end
      step();
    end
    bus_if.mshr_cnt = 4'(N_MSHR);
    step();
    n_chk++;
    if (bus_if.fence_timeout !== 1'b1 || flags() !== 4'b0001) begin
      n_fail++; $display("FAIL timeout_done tmo=%b flags=%b exp 1/0001", bus_if.fence_timeout, flags());
    end
    step();
    n_chk++;
    if (bus_if.fence_timeout !== 1'b1) begin n_fail++; $display("FAIL timeout_sticky got=%b exp=1", bus_if.fence_timeout); end
  endtask
`endif

  // Model: phase 0 idle, 1 walk, 2 writeback, 3 drain, 4 done; position is a linear line number.
  task automatic test_random();
    int   phase, line, dcnt;
    logic err, tmo, adv;
    logic [3:0] e_flags;
    quiet();
    rst = 1'b1;
    step();
    rst = 1'b0;
    phase = 0; line = 0; dcnt = 0; err = 1'b0; tmo = 1'b0;
    for (int c = 0; c < 800; c++) begin
      bus_if.do_fence         = ($urandom % 8) == 0;
      bus_if.fence_flush      = $urandom % 2;
      bus_if.do_ongoing_fence = $urandom % 2;
      bus_if.line_needs_wb    = ($urandom % 4) == 0;
      bus_if.wb_req_ready     = $urandom % 2;
      bus_if.mshr_cnt         = (($urandom % 3) == 0) ? 4'($urandom_range(0, N_MSHR - 1)) : 4'(N_MSHR);
      rst                     = ($urandom % 64) == 0;
      adv = 1'b0;
      if (rst) begin
        phase = 0; line = 0; dcnt = 0; err = 1'b0; tmo = 1'b0;
      end else begin
        if (bus_if.do_fence && phase != 0) err = 1'b1;
        case (phase)
          0: if (bus_if.do_fence) begin
               phase = bus_if.fence_flush ? 1 : 3; line = 0; dcnt = 0; tmo = 1'b0;
             end
          1: if (bus_if.do_ongoing_fence) begin
               if (bus_if.line_needs_wb) phase = 2;
               else adv = 1'b1;
             end
          2: if (bus_if.wb_req_ready) adv = 1'b1;
          3: begin
               dcnt++;
`ifdef L2_FENCE_TIMEOUT_EN
               if (dcnt == TMO) tmo = 1'b1;
`endif
               if (bus_if.mshr_cnt == 4'(N_MSHR)) phase = 4;
             end
          default: phase = 0;
        endcase
        if (adv) begin
          line++;
          if (line == LINES) begin line = 0; phase = 3; dcnt = 0; end
          else phase = 1;
        end
      end
      e_flags = {(phase >= 1 && phase <= 3), (phase == 2 || phase == 3), (phase == 2), (phase == 4)};
      step();
      n_chk++;
      if (flags() !== e_flags) begin n_fail++; $display("FAIL rnd_flags c=%0d got=%b exp=%b", c, flags(), e_flags); end
      n_chk++;
      if (bus_if.flush_set !== 1'(line / WAYS) || bus_if.flush_way !== 1'(line % WAYS)) begin
        n_fail++; $display("FAIL rnd_idx c=%0d got=%b exp line=%0d", c, idx(), line);
      end
      n_chk++;
      if (bus_if.fence_err !== err) begin n_fail++; $display("FAIL rnd_err c=%0d got=%b exp=%b", c, bus_if.fence_err, err); end
      n_chk++;
      if (bus_if.fence_timeout !== tmo) begin n_fail++; $display("FAIL rnd_tmo c=%0d got=%b exp=%b", c, bus_if.fence_timeout, tmo); end
    end
    rst = 1'b0;
    quiet();
  endtask

  initial begin
    rst = 1'b1;
    quiet();
    test_reset();
    test_drain_only();
    test_clean_walk();
    test_wb_stall();
    test_mshr_drain();
    test_reset_err();
`ifdef L2_FENCE_TIMEOUT_EN
    test_timeout();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
